// File: rtl/hop_enc_tx.sv
// rtl/hop_enc_tx.sv - binary hop count to one-hot radix-4 hop digit transmitter
//
// Accepts one binary hop word per in_vld/in_rdy handshake and emits it least
// significant digit first as one-hot 1-of-4 digits over out_vld/out_rdy.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   rst      - synchronous active-high reset
//   in_vld   - binary hop word valid
//   in_rdy   - word can be accepted (IDLE only, low while rst is high)
//   in_hop   - binary hop count, 2*NDIG bits, digit k = in_hop[2k+1:2k]
//   out_vld  - digit valid
//   out_rdy  - downstream accepts digit
//   out_d    - one-hot digit, 4'b0000 when out_vld is low
//   out_last - current digit is the final digit of the word
//   out_zero - current digit value is 0
//   busy     - word in progress
//
// Optional feature macro: HOP_ENC_ZSKIP_EN (leading-zero suppression).

module hop_enc_tx #(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    output logic                in_rdy,
    input  logic [2*NDIG-1:0]   in_hop,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [3:0]          out_d,
    output logic                out_last,
    output logic                out_zero,
    output logic                busy
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2*NDIG-1:0]   r_shreg;
    logic [IW-1:0]       r_idx;
    logic                w_load;
    logic                w_shift;
    logic                w_last;
    logic [1:0]          w_dig;

    assign w_dig = r_shreg[1:0];

`ifdef HOP_ENC_ZSKIP_EN
    // Shifting first avoids an empty part-select when NDIG is 1.
    logic [2*NDIG-1:0]   w_upper;
    assign w_upper = r_shreg >> 2;
    assign w_last  = (w_upper == '0) || (r_idx == LAST_IDX);
`else
    assign w_last  = (r_idx == LAST_IDX);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        in_rdy      = 1'b0;
        out_vld     = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst so the block never advertises readiness while
                // it is being reset.
                in_rdy = ~rst;
                if (in_vld) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                out_vld = 1'b1;
                busy    = 1'b1;
                if (out_rdy) begin
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_shreg <= in_hop;
            r_idx   <= '0;
        end else if (w_shift) begin
            r_shreg <= r_shreg >> 2;
            r_idx   <= r_idx + IW'(1);
        end
    end

    // Digit outputs are decoded from registered state only, so they stay
    // stable across a stall and have no path from out_rdy or in_vld.
    assign out_d    = out_vld ? (4'b0001 << w_dig) : 4'b0000;
    assign out_zero = out_vld & (w_dig == 2'd0);
    assign out_last = out_vld & w_last;

endmodule

// File: tb/tb_hop_enc_tx.sv
// tb/tb_hop_enc_tx.sv - self-checking randomized bench for hop_enc_tx

module tb_hop_enc_tx;

    localparam int NDIG = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_vld;
    logic              in_rdy;
    logic [2*NDIG-1:0] in_hop;
    logic              out_vld;
    logic              out_rdy;
    logic [3:0]        out_d;
    logic              out_last;
    logic              out_zero;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    int   m_q[$];
    bit   m_busy = 1'b0;
    logic [3:0] s_d;
    logic       s_last;

    hop_enc_tx #(.NDIG(NDIG)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_hop   (in_hop),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_d    (out_d),
        .out_last (out_last),
        .out_zero (out_zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Digit list of a word: plain base-4 arithmetic, trimmed of high zeros
    // when suppression is enabled (a zero word still sends one digit).
    task automatic model_load(input int h);
        int n;
        int dg[NDIG];
        n = NDIG;
        for (int k = 0; k < NDIG; k++) dg[k] = (h / (4 ** k)) % 4;
`ifdef HOP_ENC_ZSKIP_EN
        n = 1;
        for (int k = 0; k < NDIG; k++) if (dg[k] != 0) n = k + 1;
`endif
        m_q.delete();
        for (int k = 0; k < n; k++) m_q.push_back(dg[k]);
    endtask

    task automatic cyc(input logic r, input logic v, input logic [2*NDIG-1:0] h, input logic rd);
        int d;
        rst = r; in_vld = v; in_hop = h; out_rdy = rd;
        @(negedge clk);
        check("in_rdy",  32'(in_rdy),  32'(!m_busy && !r));
        check("out_vld", 32'(out_vld), 32'(m_busy));
        check("busy",    32'(busy),    32'(m_busy));
        if (m_busy) begin
            d = m_q[0];
            check("out_d",    32'(out_d),    32'(1 << d));
            check("out_last", 32'(out_last), 32'(m_q.size() == 1));
            check("out_zero", 32'(out_zero), 32'(d == 0));
        end else begin
            check("out_d_idle",    32'(out_d),    32'h0);
            check("out_last_idle", 32'(out_last), 32'h0);
            check("out_zero_idle", 32'(out_zero), 32'h0);
        end
        s_d = out_d;
        s_last = out_last;
        if (r) begin
            m_busy = 1'b0;
            m_q.delete();
        end else if (!m_busy) begin
            if (v) begin
                model_load(int'(h));
                m_busy = 1'b1;
            end
        end else if (rd) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * NDIG && m_busy; i++) cyc(1'b0, 1'b0, '0, 1'b1);
        check("drain_bound", 32'(m_busy), 32'h0);
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_hop = '0; out_rdy = 1'b0;
        @(posedge clk); #1;
        cyc(1'b1, 1'b1, 8'hE4, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0);

        // E4 at full rate: 0001,0010,0100,1000, last only on 4th
        cyc(1'b0, 1'b1, 8'hE4, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1); check("e4_d0", 32'(s_d), 32'h1); check("e4_l0", 32'(s_last), 32'h0);
        cyc(1'b0, 1'b0, '0, 1'b1); check("e4_d1", 32'(s_d), 32'h2);
        cyc(1'b0, 1'b0, '0, 1'b1); check("e4_d2", 32'(s_d), 32'h4);
        cyc(1'b0, 1'b0, '0, 1'b1); check("e4_d3", 32'(s_d), 32'h8); check("e4_l3", 32'(s_last), 32'h1);
        cyc(1'b0, 1'b0, '0, 1'b1); check("e4_rdy_back", 32'(in_rdy), 32'h1);

        // Stall three cycles on the second digit
        cyc(1'b0, 1'b1, 8'hE4, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, '0, 1'b0); check("stall_hold", 32'(s_d), 32'h2);
        end
        cyc(1'b0, 1'b0, '0, 1'b1); check("stall_d1", 32'(s_d), 32'h2);
        cyc(1'b0, 1'b0, '0, 1'b1); check("stall_d2", 32'(s_d), 32'h4);
        cyc(1'b0, 1'b0, '0, 1'b1); check("stall_d3", 32'(s_d), 32'h8);

        // 06 and 00: digit count depends on suppression
        cyc(1'b0, 1'b1, 8'h06, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1); check("w06_d0", 32'(s_d), 32'h4);
        cyc(1'b0, 1'b0, '0, 1'b1); check("w06_d1", 32'(s_d), 32'h2);
`ifdef HOP_ENC_ZSKIP_EN
        check("w06_last", 32'(s_last), 32'h1);
`else
        check("w06_last", 32'(s_last), 32'h0);
`endif
        drain();
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1); check("w00_d0", 32'(s_d), 32'h1);
`ifdef HOP_ENC_ZSKIP_EN
        check("w00_last", 32'(s_last), 32'h1);
`else
        check("w00_last", 32'(s_last), 32'h0);
`endif
        drain();

        // in_vld held with changing in_hop during SEND
        cyc(1'b0, 1'b1, 8'h39, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'(8'hA0 + i), 1'b1);
        drain();

        // Reset one cycle after the second digit handshake, then 1B
        cyc(1'b0, 1'b1, 8'hE4, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0); check("rst_busy", 32'(busy), 32'h0);
        cyc(1'b0, 1'b1, 8'h1B, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1); check("w1b_d0", 32'(s_d), 32'h8);
        cyc(1'b0, 1'b0, '0, 1'b1); check("w1b_d1", 32'(s_d), 32'h4);
        cyc(1'b0, 1'b0, '0, 1'b1); check("w1b_d2", 32'(s_d), 32'h2);
        cyc(1'b0, 1'b0, '0, 1'b1); check("w1b_d3", 32'(s_d), 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [2*NDIG-1:0] h;
            h = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), h,
                ($urandom_range(0, 9) < 7));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
